// File: rtl/jpc_idecode_if.sv
// Fetch-to-decode bus of the jpc decode stage: instruction/PC in, decoded fields out.
interface jpc_idecode_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  stall_I;
    logic                  flush_I;
    logic [31:0]           instr_I;
    logic [ADDR_WIDTH-1:0] pc_I;

    logic                  hazard_O;
    logic                  valid_O;
    logic [ADDR_WIDTH-1:0] pc_O;
    logic [4:0]            rs1_O;
    logic [4:0]            rs2_O;
    logic [4:0]            rd_O;
    logic [2:0]            funct3_O;
    logic                  alt_O;
    logic [31:0]           imm_O;
    logic [9:0]            class_O;
    logic                  reg_write_O;
    logic                  mem_read_O;
    logic                  mem_write_O;
    logic                  illegal_O;

    // Fetch/pipeline side: drives the instruction, consumes the decode.
    modport master (
        output stall_I, flush_I, instr_I, pc_I,
        input  hazard_O, valid_O, pc_O, rs1_O, rs2_O, rd_O, funct3_O, alt_O, imm_O,
        input  class_O, reg_write_O, mem_read_O, mem_write_O, illegal_O
    );

    // Decode stage side.
    modport slave (
        input  stall_I, flush_I, instr_I, pc_I,
        output hazard_O, valid_O, pc_O, rs1_O, rs2_O, rd_O, funct3_O, alt_O, imm_O,
        output class_O, reg_write_O, mem_read_O, mem_write_O, illegal_O
    );
endinterface

// File: rtl/jpc_idecode.sv
// jpc RV32I decode stage: registers decoded fields for execute and raises the
// load-use hazard that stalls fetch and injects a single bubble.
module jpc_idecode #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    jpc_idecode_if.slave bus
);
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpReg     = 7'b0110011;
    localparam logic [6:0] OpSystem  = 7'b1110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;

    localparam int unsigned ClsLui    = 0;
    localparam int unsigned ClsAuipc  = 1;
    localparam int unsigned ClsJal    = 2;
    localparam int unsigned ClsJalr   = 3;
    localparam int unsigned ClsBranch = 4;
    localparam int unsigned ClsLoad   = 5;
    localparam int unsigned ClsStore  = 6;
    localparam int unsigned ClsOpImm  = 7;
    localparam int unsigned ClsOp     = 8;
    localparam int unsigned ClsSystem = 9;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [2:0]            funct3;
        logic                  alt;
        logic [31:0]           imm;
        logic [9:0]            cls;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  illegal;
    } dec_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign instr  = bus.instr_I;
    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    logic [9:0]  cls;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        illegal;
    logic        legal;
    logic [31:0] imm;

    // Opcode decode: class, operand usage, immediate format and legality.
    always_comb begin
        cls     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        case (opcode)
            OpLui: begin
                cls[ClsLui] = 1'b1;
                use_rd      = 1'b1;
                imm         = {instr[31:12], 12'b0};
            end
            OpAuipc: begin
                cls[ClsAuipc] = 1'b1;
                use_rd        = 1'b1;
                imm           = {instr[31:12], 12'b0};
            end
            OpJal: begin
                cls[ClsJal] = 1'b1;
                use_rd      = 1'b1;
                imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OpJalr: begin
                cls[ClsJalr] = 1'b1;
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
                imm          = {{20{instr[31]}}, instr[31:20]};
                illegal      = (funct3 != 3'b000);
            end
            OpBranch: begin
                cls[ClsBranch] = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                illegal        = (funct3[2:1] == 2'b01);
            end
            OpLoad: begin
                cls[ClsLoad] = 1'b1;
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
                imm          = {{20{instr[31]}}, instr[31:20]};
                illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OpStore: begin
                cls[ClsStore] = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                imm           = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                illegal       = (funct3 > 3'b010);
            end
            OpImm: begin
                cls[ClsOpImm] = 1'b1;
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
                imm           = {{20{instr[31]}}, instr[31:20]};
                // Shift-immediates reuse the top of the immediate as funct7.
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
                end
            end
            OpReg: begin
                cls[ClsOp] = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                use_rd     = 1'b1;
                illegal    = !((funct7 == 7'b0000000) ||
                               ((funct7 == 7'b0100000) &&
                                ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OpSystem: begin
                cls[ClsSystem] = 1'b1;
                illegal        = !((instr == 32'h0000_0073) || (instr == 32'h0010_0073));
            end
            OpMiscMem: begin
                // FENCE is a no-op in this in-order pipeline.
            end
            default: illegal = 1'b1;
        endcase
    end

    assign legal = ~illegal;

    dec_t dec;
    dec_t out_q;
    dec_t out_d;
    logic hazard;

    // Fields for a non-bubble instruction; illegal ones carry only valid/illegal/pc.
    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc      = bus.pc_I;
        dec.illegal = illegal;
        if (legal) begin
            dec.rs1       = use_rs1 ? rs1 : 5'd0;
            dec.rs2       = use_rs2 ? rs2 : 5'd0;
            dec.rd        = use_rd ? rd : 5'd0;
            dec.funct3    = funct3;
            dec.alt       = ((opcode == OpReg) || ((opcode == OpImm) && (funct3 == 3'b101)))
                            && instr[30];
            dec.imm       = imm;
            dec.cls       = cls;
            dec.reg_write = use_rd && (rd != 5'd0);
            dec.mem_read  = cls[ClsLoad];
            dec.mem_write = cls[ClsStore];
        end
    end

    // Load in decode whose destination the incoming instruction reads.
    assign hazard = out_q.valid && out_q.mem_read && (out_q.rd != 5'd0) && legal &&
                    ((use_rs1 && (rs1 == out_q.rd)) || (use_rs2 && (rs2 == out_q.rd)));

    // Register update priority: flush, stall, hazard bubble, zero-word bubble, decode.
    always_comb begin
        out_d = out_q;
        if (bus.flush_I) begin
            out_d = '0;
        end else if (bus.stall_I) begin
            out_d = out_q;
        end else if (hazard || (instr == 32'd0)) begin
            out_d = '0;
        end else begin
            out_d = dec;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.hazard_O    = hazard;
    assign bus.valid_O     = out_q.valid;
    assign bus.pc_O        = out_q.pc;
    assign bus.rs1_O       = out_q.rs1;
    assign bus.rs2_O       = out_q.rs2;
    assign bus.rd_O        = out_q.rd;
    assign bus.funct3_O    = out_q.funct3;
    assign bus.alt_O       = out_q.alt;
    assign bus.imm_O       = out_q.imm;
    assign bus.class_O     = out_q.cls;
    assign bus.reg_write_O = out_q.reg_write;
    assign bus.mem_read_O  = out_q.mem_read;
    assign bus.mem_write_O = out_q.mem_write;
    assign bus.illegal_O   = out_q.illegal;
endmodule

// File: tb/tb_jpc_idecode.sv
// Scoreboard bench for jpc_idecode: a reference decoder predicts each cycle's
// registered outputs and hazard; a monitor compares them on the falling edge.
module tb_jpc_idecode;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst;

    jpc_idecode_if #(.ADDR_WIDTH(AW)) bus ();

    jpc_idecode #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        alt;
        logic [31:0] imm;
        logic [9:0]  cls;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    typedef struct {
        exp_t o;
        logic hz;
    } sb_t;

    sb_t  sbq[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference decoder: class index from an opcode table, legality from the rule list.
    function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] pc);
        exp_t        e;
        logic [6:0]  opcs [10];
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] im;
        int          k;
        bit          ok;
        bit          u1;
        bit          u2;
        bit          ud;
        e    = '0;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        f7   = w[31:25];
        f3   = w[14:12];
        if (w == 32'd0) return e;
        k = -1;
        for (int i = 0; i < 10; i++) if (opcs[i] == w[6:0]) k = i;
        case (k)
            -1:      ok = (w[6:0] == 7'h0F);
            3:       ok = (f3 == 3'd0);
            4:       ok = !(f3 == 3'd2 || f3 == 3'd3);
            5:       ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
            6:       ok = (f3 <= 3'd2);
            7:       ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                          (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            8:       ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            9:       ok = (w == 32'h0000_0073 || w == 32'h0010_0073);
            default: ok = 1'b1;
        endcase
        e.valid = 1'b1;
        e.pc    = pc;
        if (!ok) begin
            e.ill = 1'b1;
            return e;
        end
        u1 = (k >= 3 && k <= 8);
        u2 = (k == 4 || k == 6 || k == 8);
        ud = (k == 0 || k == 1 || k == 2 || k == 3 || k == 5 || k == 7 || k == 8);
        case (k)
            0, 1:    im = {w[31:12], 12'd0};
            2:       im = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            3, 5, 7: im = {{20{w[31]}}, w[31:20]};
            4:       im = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            6:       im = {{20{w[31]}}, w[31:25], w[11:7]};
            default: im = 32'd0;
        endcase
        e.rs1    = u1 ? w[19:15] : 5'd0;
        e.rs2    = u2 ? w[24:20] : 5'd0;
        e.rd     = ud ? w[11:7] : 5'd0;
        e.funct3 = f3;
        e.alt    = (k == 8 || (k == 7 && f3 == 3'd5)) ? w[30] : 1'b0;
        e.imm    = im;
        e.cls    = (k >= 0) ? (10'd1 << k) : 10'd0;
        e.rw     = ud && (w[11:7] != 5'd0);
        e.mr     = (k == 5);
        e.mw     = (k == 6);
        return e;
    endfunction

    function automatic logic hazard_of(exp_t c, logic [31:0] w);
        exp_t d;
        d = ref_decode(w, 32'd0);
        return c.valid && c.mr && (c.rd != 5'd0) && (d.rs1 == c.rd || d.rs2 == c.rd);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [6:0]  f7;
        int          sel;
        r   = $urandom;
        rd  = 5'($urandom_range(0, 3));
        s1  = 5'($urandom_range(0, 3));
        s2  = 5'($urandom_range(0, 3));
        f7  = ($urandom_range(0, 3) == 0) ? r[31:25] : (r[0] ? 7'h20 : 7'h00);
        sel = $urandom_range(0, 13);
        case (sel)
            0:       return {r[31:12], rd, 7'h37};
            1:       return {r[31:12], rd, 7'h17};
            2:       return {r[31:12], rd, 7'h6F};
            3:       return {r[31:20], s1, (r[1] ? r[14:12] : 3'd0), rd, 7'h67};
            4:       return {r[31:25], s2, s1, r[14:12], r[11:7], 7'h63};
            5, 13:   return {r[31:20], s1, r[14:12], rd, 7'h03};
            6:       return {r[31:25], s2, s1, r[14:12], r[11:7], 7'h23};
            7:       return {f7, r[24:20], s1, r[14:12], rd, 7'h13};
            8:       return {f7, s2, s1, r[14:12], rd, 7'h33};
            9:       return r[2] ? 32'h0000_0073 : (r[3] ? 32'h0010_0073 : {r[31:7], 7'h73});
            10:      return {r[31:7], 7'h0F};
            11:      return 32'd0;
            default: return r;
        endcase
    endfunction

    // Present inputs after a rising edge, queue the prediction, then advance the model.
    task automatic apply(logic [31:0] w, logic [31:0] pc, logic st, logic fl);
        logic hz;
        sb_t  ent;
        @(posedge clk);
        #1;
        bus.instr_I = w;
        bus.pc_I    = pc;
        bus.stall_I = st;
        bus.flush_I = fl;
        hz     = hazard_of(cur, w);
        ent.o  = cur;
        ent.hz = hz;
        sbq.push_back(ent);
        if (fl || (!st && hz)) cur = '0;
        else if (!st) cur = ref_decode(w, pc);
    endtask

    // Monitor: compare every registered output and the hazard against the queue.
    sb_t m;
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                m = sbq.pop_front();
                chk("valid", 32'(bus.valid_O), 32'(m.o.valid));
                chk("pc", bus.pc_O, m.o.pc);
                chk("rs1", 32'(bus.rs1_O), 32'(m.o.rs1));
                chk("rs2", 32'(bus.rs2_O), 32'(m.o.rs2));
                chk("rd", 32'(bus.rd_O), 32'(m.o.rd));
                chk("funct3", 32'(bus.funct3_O), 32'(m.o.funct3));
                chk("alt", 32'(bus.alt_O), 32'(m.o.alt));
                chk("imm", bus.imm_O, m.o.imm);
                chk("class", 32'(bus.class_O), 32'(m.o.cls));
                chk("reg_write", 32'(bus.reg_write_O), 32'(m.o.rw));
                chk("mem_read", 32'(bus.mem_read_O), 32'(m.o.mr));
                chk("mem_write", 32'(bus.mem_write_O), 32'(m.o.mw));
                chk("illegal", 32'(bus.illegal_O), 32'(m.o.ill));
                chk("hazard", 32'(bus.hazard_O), 32'(m.hz));
            end
        end
    end

    logic [31:0] w;
    logic [31:0] last_w;
    logic [31:0] pc;
    logic        st;
    logic        fl;

    initial begin
        cur         = '0;
        rst         = 1'b1;
        bus.instr_I = 32'd0;
        bus.pc_I    = 32'd0;
        bus.stall_I = 1'b0;
        bus.flush_I = 1'b0;
        #12;
        chk("reset_valid", 32'(bus.valid_O), 32'd0);
        chk("reset_imm", bus.imm_O, 32'd0);
        chk("reset_pc", bus.pc_O, 32'd0);
        chk("reset_class", 32'(bus.class_O), 32'd0);
        chk("reset_illegal", 32'(bus.illegal_O), 32'd0);
        rst = 1'b0;

        // addi x1,x0,5 then beq x0,x0,-8
        apply(32'h0050_0093, 32'h100, 1'b0, 1'b0);
        apply(32'hFE00_0CE3, 32'h104, 1'b0, 1'b0);
        chk("addi_imm", bus.imm_O, 32'd5);
        chk("addi_rd", 32'(bus.rd_O), 32'd1);
        chk("addi_class", 32'(bus.class_O), 32'h080);
        chk("addi_pc", bus.pc_O, 32'h100);
        // lw x2,0(x1) then add x3,x2,x1: one bubble
        apply(32'h0000_A103, 32'h108, 1'b0, 1'b0);
        chk("beq_imm", bus.imm_O, 32'hFFFF_FFF8);
        chk("beq_rw", 32'(bus.reg_write_O), 32'd0);
        apply(32'h0011_01B3, 32'h10C, 1'b0, 1'b0);
        #1 chk("lu_hazard", 32'(bus.hazard_O), 32'd1);
        apply(32'h0011_01B3, 32'h10C, 1'b0, 1'b0);
        chk("lu_bubble", 32'(bus.valid_O), 32'd0);
        apply(32'h0000_0013, 32'h110, 1'b0, 1'b0);
        chk("add_rs1", 32'(bus.rs1_O), 32'd2);
        chk("add_rs2", 32'(bus.rs2_O), 32'd1);
        chk("add_rd", 32'(bus.rd_O), 32'd3);
        // lw x0 then add using x0: no hazard
        apply(32'h0000_2003, 32'h114, 1'b0, 1'b0);
        apply(32'h0000_02B3, 32'h118, 1'b0, 1'b0);
        #1 chk("x0_no_hazard", 32'(bus.hazard_O), 32'd0);
        apply(32'hFFFF_FFFF, 32'h11C, 1'b0, 1'b0);
        apply(32'h0000_0013, 32'h120, 1'b0, 1'b0);
        chk("ill_flag", 32'(bus.illegal_O), 32'd1);
        chk("ill_valid", 32'(bus.valid_O), 32'd1);
        chk("ill_rw", 32'(bus.reg_write_O), 32'd0);
        // stall three cycles, then flush together with stall, then a zero word
        apply(32'h00A0_0113, 32'h124, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(rand_instr(), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
        apply(32'h0050_0093, 32'h300, 1'b1, 1'b1);
        chk("stall_hold_imm", bus.imm_O, 32'd10);
        apply(32'd0, 32'h304, 1'b0, 1'b0);
        chk("flush_bubble", 32'(bus.valid_O), 32'd0);
        apply(32'h0000_0013, 32'h308, 1'b0, 1'b0);
        chk("zero_valid", 32'(bus.valid_O), 32'd0);
        chk("zero_illegal", 32'(bus.illegal_O), 32'd0);

        // Random stream; fetch holds the instruction while a hazard is signalled.
        last_w = 32'h0000_0013;
        pc     = 32'h400;
        for (int i = 0; i < 600; i++) begin
            if (hazard_of(cur, last_w)) begin
                w = last_w;
            end else begin
                w  = rand_instr();
                pc = pc + 32'd4;
            end
            st = ($urandom_range(0, 99) < 15);
            fl = ($urandom_range(0, 99) < 6);
            apply(w, pc, st, fl);
            last_w = w;
        end

        // Asynchronous reset mid-stream.
        apply(32'h0050_0093, 32'h800, 1'b0, 1'b0);
        apply(32'h0050_0093, 32'h804, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        bus.instr_I = 32'd0;
        bus.stall_I = 1'b0;
        bus.flush_I = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.valid_O), 32'd0);
        chk("arst_imm", bus.imm_O, 32'd0);
        chk("arst_pc", bus.pc_O, 32'd0);
        chk("arst_rd", 32'(bus.rd_O), 32'd0);
        chk("arst_rw", 32'(bus.reg_write_O), 32'd0);
        #1 rst = 1'b0;
        cur = '0;
        apply(32'h0000_0093, 32'h900, 1'b0, 1'b0);
        apply(32'd0, 32'h904, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
